// File: rtl/bsg_mem_1rw_sync_mask_write_byte_requester.sv
// Initiator for a 1rw sync byte-masked memory; responses are buffered in a small FIFO.
// Latency: read accepted in cycle t is presented on data_o/v_o from cycle t+2.
// Backpressure: ready_o drops when buffered plus in-flight reads would exceed resp_els_p.
module bsg_mem_1rw_sync_mask_write_byte_requester #(
    parameter int width_p    = 32,
    parameter int els_p      = 16,
    parameter int resp_els_p = 3,
    localparam int write_mask_width_lp = width_p >> 3,
    localparam int addr_width_lp       = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    input  logic                           w_i,
    input  logic [addr_width_lp-1:0]       addr_i,
    input  logic [width_p-1:0]             data_i,
    input  logic [write_mask_width_lp-1:0] w_mask_i,
    output logic                           ready_o,
    output logic [width_p-1:0]             data_o,
    output logic                           v_o,
    input  logic                           yumi_i,
    output logic                           mem_v_o,
    output logic                           mem_w_o,
    output logic [addr_width_lp-1:0]       mem_addr_o,
    output logic [width_p-1:0]             mem_data_o,
    output logic [write_mask_width_lp-1:0] mem_w_mask_o,
    input  logic [width_p-1:0]             mem_data_i
);

    localparam int cnt_w_lp = $clog2(resp_els_p + 1);
    localparam int ptr_w_lp = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
    localparam logic [cnt_w_lp:0]   credits_lp  = (cnt_w_lp + 1)'(resp_els_p);
    localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(resp_els_p - 1);

    logic [cnt_w_lp-1:0] count_r;
    logic [ptr_w_lp-1:0] wptr_r;
    logic [ptr_w_lp-1:0] rptr_r;
    logic                rd_inflight_r;
    logic [width_p-1:0]  buf_r [resp_els_p];

    logic [cnt_w_lp:0]   used;
    logic                enq;
    logic                deq;

    // Credits count reads in flight so the returning data always has a slot.
    assign used    = {1'b0, count_r} + {{cnt_w_lp{1'b0}}, rd_inflight_r};
    assign ready_o = ~reset_i & (used < credits_lp);

    assign mem_v_o      = v_i & ready_o;
    assign mem_w_o      = w_i;
    assign mem_addr_o   = addr_i;
    assign mem_data_o   = data_i;
    assign mem_w_mask_o = w_mask_i;

    assign v_o    = ~reset_i & (count_r != '0);
    assign data_o = buf_r[rptr_r];

    assign enq = rd_inflight_r & ~reset_i;
    assign deq = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_inflight_r <= 1'b0;
            count_r       <= '0;
            wptr_r        <= '0;
            rptr_r        <= '0;
        end else begin
            rd_inflight_r <= mem_v_o & ~w_i;
            if (enq) begin
                wptr_r <= (wptr_r == ptr_last_lp) ? '0 : wptr_r + 1'b1;
            end
            if (deq) begin
                rptr_r <= (rptr_r == ptr_last_lp) ? '0 : rptr_r + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked entirely by count_r.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            buf_r[wptr_r] <= mem_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o));
        end
    end

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte_requester.sv
// Directed bench: drives the requester against a behavioural 1rw byte-masked sync memory.
module tb_bsg_mem_1rw_sync_mask_write_byte_requester;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic        w_i;
    logic [3:0]  addr_i;
    logic [31:0] data_i;
    logic [3:0]  w_mask_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic        v_o;
    logic        yumi_i;
    logic        yumi_man;
    logic        tie_yumi;
    logic        mem_v_o;
    logic        mem_w_o;
    logic [3:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_w_mask_o;
    logic [31:0] mem_data_i;
    logic [31:0] tbmem [16];
    logic [31:0] held;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk_i = ~clk_i;

    assign yumi_i = tie_yumi ? v_o : yumi_man;

    bsg_mem_1rw_sync_mask_write_byte_requester #(
        .width_p(32), .els_p(16), .resp_els_p(3)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .w_i(w_i), .addr_i(addr_i),
        .data_i(data_i), .w_mask_i(w_mask_i), .ready_o(ready_o), .data_o(data_o),
        .v_o(v_o), .yumi_i(yumi_i), .mem_v_o(mem_v_o), .mem_w_o(mem_w_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o),
        .mem_data_i(mem_data_i)
    );

    // Behavioural synchronous memory: read data appears after the access edge.
    always @(posedge clk_i) begin
        if (mem_v_o) begin
            if (mem_w_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_w_mask_o[b]) tbmem[mem_addr_o][b*8 +: 8] <= mem_data_o[b*8 +: 8];
                end
            end else begin
                mem_data_i <= tbmem[mem_addr_o];
            end
        end
    end

    function automatic logic [31:0] pat(int k);
        return 32'h10203040 + 32'(k) * 32'h01010101;
    endfunction

    // Expected contents after the masked write to address 5.
    function automatic logic [31:0] exp_rd(int k);
        return (k == 5) ? 32'h11BB33DD : pat(k);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbmem[i] = pat(i);
        tbmem[5] = 32'h11223344;
        mem_data_i = '0;
        reset_i = 1'b1; v_i = 1'b1; w_i = 1'b0; addr_i = '0; data_i = '0; w_mask_i = '0;
        yumi_man = 1'b0; tie_yumi = 1'b0;

        // Reset with a pending command: nothing may issue.
        step();
        sample();
        check("rst_ready", ready_o, 1'b0);
        check("rst_v_o", v_o, 1'b0);
        check("rst_mem_v", mem_v_o, 1'b0);
        step();
        reset_i = 1'b0; v_i = 1'b0;
        sample();
        check("post_rst_ready", ready_o, 1'b1);
        check("post_rst_v_o", v_o, 1'b0);
        check("post_rst_mem_v", mem_v_o, 1'b0);

        // Masked write then read of address 5.
        step();
        v_i = 1'b1; w_i = 1'b1; addr_i = 4'd5; data_i = 32'hAABBCCDD; w_mask_i = 4'b0101;
        sample();
        check("wr_mem_v", mem_v_o, 1'b1);
        check("wr_mem_w", mem_w_o, 1'b1);
        check("wr_mask", mem_w_mask_o, 4'b0101);
        step();
        w_i = 1'b0; data_i = '0; w_mask_i = '0;
        sample();
        check("rd5_ready", ready_o, 1'b1);
        step();
        v_i = 1'b0;
        sample();
        check("rd5_v_t1", v_o, 1'b0);
        step();
        sample();
        check("rd5_v_t2", v_o, 1'b1);
        check("rd5_data", data_o, 32'h11BB33DD);
        yumi_man = 1'b1;
        step();
        yumi_man = 1'b0;
        sample();
        check("rd5_drained", v_o, 1'b0);

        // Back-to-back reads 0..15 with yumi tied to v_o.
        tie_yumi = 1'b1;
        for (int c = 0; c < 18; c++) begin
            step();
            v_i = (c < 16); w_i = 1'b0; addr_i = 4'(c);
            sample();
            if (c < 16) check($sformatf("b2b_ready%0d", c), ready_o, 1'b1);
            if (c >= 2) begin
                check($sformatf("b2b_v%0d", c - 2), v_o, 1'b1);
                check($sformatf("b2b_data%0d", c - 2), data_o, exp_rd(c - 2));
            end
        end
        step();
        tie_yumi = 1'b0;
        sample();
        check("b2b_idle", v_o, 1'b0);

        // Stalled consumer: three reads accepted, then ready drops.
        for (int c = 0; c < 6; c++) begin
            step();
            v_i = 1'b1; addr_i = (c < 3) ? 4'(c) : 4'd3;
            sample();
            check($sformatf("stall_ready%0d", c), ready_o, (c < 3) ? 1'b1 : 1'b0);
            if (c == 2) held = data_o;
        end
        check("stall_head", held, pat(0));
        check("stall_hold", data_o, pat(0));
        yumi_man = 1'b1;
        step();
        yumi_man = 1'b0;
        sample();
        check("stall_ready_back", ready_o, 1'b1);
        step();
        v_i = 1'b0;
        sample();
        check("drain_1", data_o, pat(1));
        yumi_man = 1'b1;
        step();
        sample();
        check("drain_2", data_o, pat(2));
        step();
        sample();
        check("drain_3", data_o, pat(3));
        step();
        yumi_man = 1'b0;
        sample();
        check("drain_empty", v_o, 1'b0);

        // Interleaved W/R/W/R to address 9.
        tie_yumi = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step();
            v_i = (c < 4); w_i = (c == 0) || (c == 2); addr_i = 4'd9;
            data_i = (c == 0) ? 32'h01020304 : 32'hA0B0C0D0;
            w_mask_i = (c == 0) ? 4'b0011 : 4'b1100;
            sample();
            check($sformatf("il_v%0d", c), v_o, (c == 3) || (c == 5));
            if (c == 3) check("il_rd1", data_o, 32'h19290304);
            if (c == 5) check("il_rd2", data_o, 32'hA0B00304);
        end
        tie_yumi = 1'b0;

        // Reset while two responses are buffered and a read is in flight.
        for (int c = 0; c < 3; c++) begin
            step();
            v_i = 1'b1; w_i = 1'b0; addr_i = 4'(c);
        end
        step();
        reset_i = 1'b1;
        sample();
        check("mrst_ready", ready_o, 1'b0);
        check("mrst_mem_v", mem_v_o, 1'b0);
        check("mrst_v_o", v_o, 1'b0);
        step();
        reset_i = 1'b0; v_i = 1'b0;
        sample();
        check("mrst_after_v", v_o, 1'b0);
        check("mrst_after_ready", ready_o, 1'b1);
        step();
        sample();
        check("mrst_stale", v_o, 1'b0);
        step();
        v_i = 1'b1; addr_i = 4'd7;
        sample();
        check("mrst_rd_ready", ready_o, 1'b1);
        step();
        v_i = 1'b0;
        sample();
        check("mrst_rd_t1", v_o, 1'b0);
        step();
        sample();
        check("mrst_rd_v", v_o, 1'b1);
        check("mrst_rd_data", data_o, pat(7));
        yumi_man = 1'b1;
        step();
        yumi_man = 1'b0;
        sample();
        check("mrst_final_empty", v_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/bsg_mem_1rw_sync_mask_write_byte_requester.md
# bsg_mem_1rw_sync_mask_write_byte_requester

Initiator-side controller for a single-ported synchronous byte-masked memory (1rw, read data one cycle after the request). Accepts read and write commands on a valid/ready port, drives at most one memory access per cycle, and captures the returned read data into a response FIFO. The FIFO is drained on a valid/yumi port. The block lets a consumer sit behind stall-free memory timing without ever losing read data.

## Interface
Parameters:
- width_p, "inv", data width in bits; multiple of 8.
- els_p, -1, memory depth in words.
- resp_els_p, 3, response FIFO depth; minimum 2; 3 is required for one read per cycle.
- write_mask_width_lp, width_p>>3, byte mask width (derived).
- addr_width_lp, `BSG_SAFE_CLOG2(els_p), address width (derived).

Ports:
- clk_i  in  1  clock; all state on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  command valid.
- w_i  in  1  1 = write, 0 = read.
- addr_i  in  addr_width_lp  word address.
- data_i  in  width_p  write data.
- w_mask_i  in  write_mask_width_lp  byte enables for writes; ignored on reads.
- ready_o  out  1  command accepted when v_i & ready_o.
- data_o  out  width_p  response data (FIFO head).
- v_o  out  1  response valid.
- yumi_i  in  1  consumer takes the head; legal only when v_o=1.
- mem_v_o  out  1  memory access enable.
- mem_w_o  out  1  memory write enable.
- mem_addr_o  out  addr_width_lp  memory address.
- mem_data_o  out  width_p  memory write data.
- mem_w_mask_o  out  write_mask_width_lp  memory byte mask.
- mem_data_i  in  width_p  memory read data; valid the cycle after a read.

## Operation
- Issue path is combinational pass-through:
  - mem_v_o = v_i & ready_o.
  - mem_w_o = w_i.
  - mem_addr_o, mem_data_o and mem_w_mask_o equal addr_i, data_i and w_mask_i.
- Command port has no internal buffering.
- State:
  - rd_inflight_r (1 bit): set when a read issues; cleared in the following cycle.
  - Response FIFO with count_r, 0..resp_els_p.
- Credit rule: ready_o = ~reset_i & (count_r + rd_inflight_r < resp_els_p).
  - ready_o must not depend on w_i, v_i or yumi_i.
  - Writes are therefore also stalled when credits are exhausted. This is intentional: it keeps ready_o free of input-to-output combinational paths.
- Capture: a cycle with rd_inflight_r=1 enqueues mem_data_i into the FIFO tail.
- Writes produce no response.
- Dequeue: yumi_i & v_o pops the head. Enqueue and dequeue in the same cycle leave count_r unchanged.
- v_o = (count_r != 0). data_o = head entry, held stable while v_o=1 and yumi_i=0.
- Ordering:
  - Responses leave in read-issue order.
  - Memory accesses occur in command-acceptance order, so a read after a write to the same address returns the written bytes.
- Overflow is impossible by construction.
  - yumi_i with v_o=0 is a protocol error; assert in simulation.
- FIFO pointers wrap modulo resp_els_p; resp_els_p need not be a power of 2.

## Timing
- Reset (cycle with reset_i=1):
  - ready_o=0, mem_v_o=0, v_o=0.
  - count_r=0, pointers=0, rd_inflight_r=0.
  - data_o is don't-care.
- Reset mid-operation: an in-flight read's data is discarded (no enqueue on the reset cycle or after), and all buffered responses are dropped.
- First cycle after reset deasserts: ready_o=1.
- Read accepted in cycle t:
  - mem_data_i sampled at the end of t+1.
  - v_o=1 with that data from cycle t+2.
  - Read latency is 2 cycles.
- Throughput with resp_els_p=3 and yumi_i held 1 whenever v_o=1: one read accepted every cycle, indefinitely.
- With resp_els_p=2: sustained reads at 2 per 3 cycles.
- Consumer stalled (yumi_i=0): exactly resp_els_p reads are accepted, then ready_o=0.
  - ready_o returns to 1 in the cycle after the first yumi.
- Writes take effect in the memory at the edge ending the accept cycle.

## Test plan
- Reset then idle: during reset and the cycle after, v_o=0 and mem_v_o=0; ready_o=1 from the first post-reset cycle.
- Write addr 5, data 0xAABBCCDD, mask 4'b0101; then read addr 5 over memory preloaded with 0x11223344:
  - data_o=0x11BB33DD.
  - v_o rises exactly 2 cycles after the read is accepted.
- Back-to-back reads of addresses 0..15 with yumi_i tied to v_o and resp_els_p=3:
  - ready_o stays 1 throughout.
  - 16 responses arrive in order, on 16 consecutive cycles.
- Consumer stalled with yumi_i=0 and continuous read commands:
  - exactly 3 accepted, then ready_o=0.
  - the held data_o is unchanged.
  - after one yumi_i pulse, ready_o=1 the next cycle.
- Interleaved write/read/write/read to the same address with differing masks: each read reflects every prior write, and no responses are generated for writes.
- reset_i asserted the cycle after a read issues while the FIFO holds 2 entries:
  - after reset, v_o=0 and the count is empty.
  - the stale read data never appears.
